// File: rtl/multi_window_filter_pkg.sv
// Shared types and constants for the multi-window video crop filter.
// Imported by the window comparator and the filter top level.
package multi_window_pkg;

    localparam int COORD_W_DEFAULT = 16;
    localparam int DECIM_MAX_LOG2  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_VBLANK = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/multi_window_filter_window_cmp.sv
// Inclusive rectangle test of one pixel position against one shadowed window.
// An inverted rectangle (min > max) can never satisfy both bounds, so it never hits.
module window_cmp
    import multi_window_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] ymin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymax,
    input  logic               enable,
    output logic               hit
);

    assign hit = enable && (x >= xmin) && (x <= xmax) && (y >= ymin) && (y <= ymax);

endmodule

// File: rtl/multi_window_filter.sv
// Gates active video to the union of N_WIN rectangles with optional subsampling.
// Window config is shadowed at each vsync falling edge; all outputs are registered.
module multi_window_filter
    import multi_window_pkg::*;
#(
    parameter int N_WIN   = 2,
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int DATA_W  = 24
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sw_reset,
    input  logic [DATA_W-1:0]          vid_pData_i,
    input  logic                       vid_pHSync_i,
    input  logic                       vid_pVSync_i,
    input  logic                       vid_pVDE_i,
    output logic [DATA_W-1:0]          vid_pData_o,
    output logic                       vid_pHSync_o,
    output logic                       vid_pVSync_o,
    output logic                       vid_pVDE_o,
    input  logic [N_WIN*2*COORD_W-1:0] top_left,
    input  logic [N_WIN*2*COORD_W-1:0] bottom_right,
    input  logic [N_WIN-1:0]           win_enable,
    input  logic [1:0]                 decim_log2,
    output logic [N_WIN-1:0]           win_hit,
    output logic [31:0]                frame_count,
    output logic [31:0]                last_frame_pixels
);

    localparam int CFG_W = N_WIN * 2 * COORD_W;

    state_t             state;
    state_t             state_next;
    logic               rst_n;
    logic               vsync_d1;
    logic               vde_d1;
    logic               frame_start;
    logic               vsync_rise;
    logic               line_end;
    logic               gate_open;
    logic [CFG_W-1:0]   tl_sh;
    logic [CFG_W-1:0]   br_sh;
    logic [CFG_W-1:0]   tl_eff;
    logic [CFG_W-1:0]   br_eff;
    logic [N_WIN-1:0]   en_sh;
    logic [N_WIN-1:0]   en_eff;
    logic [1:0]         dec_sh;
    logic [1:0]         dec_eff;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] x_eff;
    logic [COORD_W-1:0] y_eff;
    logic [COORD_W-1:0] decim_mask;
    logic [N_WIN-1:0]   hit;
    logic               decim_pass;
    logic               pix_valid;
    logic               vde_next;
    logic [31:0]        pix_acc;

    assign rst_n       = resetn & sw_reset;
    assign frame_start = vsync_d1 & ~vid_pVSync_i;
    assign vsync_rise  = ~vsync_d1 & vid_pVSync_i;
    assign line_end    = vde_d1 & ~vid_pVDE_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pixel arriving in the frame-start cycle already belongs to the new frame.
    always_comb begin
        state_next = state;
        gate_open  = (state != ST_IDLE) || frame_start;
        case (state)
            ST_IDLE:   if (frame_start) state_next = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise)  state_next = ST_VBLANK;
            ST_VBLANK: if (frame_start) state_next = ST_ACTIVE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign tl_eff  = frame_start ? top_left     : tl_sh;
    assign br_eff  = frame_start ? bottom_right : br_sh;
    assign en_eff  = frame_start ? win_enable   : en_sh;
    assign dec_eff = frame_start ? decim_log2   : dec_sh;
    assign x_eff   = frame_start ? '0 : x_cnt;
    assign y_eff   = frame_start ? '0 : y_cnt;

    assign decim_mask = ~({COORD_W{1'b1}} << dec_eff);
    assign decim_pass = ((x_eff & decim_mask) == '0) && ((y_eff & decim_mask) == '0);

    for (genvar i = 0; i < N_WIN; i++) begin : g_win
        window_cmp #(
            .COORD_W(COORD_W)
        ) u_cmp (
            .x      (x_eff),
            .y      (y_eff),
            .xmin   (tl_eff[2*i*COORD_W +: COORD_W]),
            .ymin   (tl_eff[(2*i+1)*COORD_W +: COORD_W]),
            .xmax   (br_eff[2*i*COORD_W +: COORD_W]),
            .ymax   (br_eff[(2*i+1)*COORD_W +: COORD_W]),
            .enable (en_eff[i]),
            .hit    (hit[i])
        );
    end

    assign pix_valid = vid_pVDE_i & decim_pass & gate_open;
    assign vde_next  = pix_valid & (|hit);

    // x_cnt holds the index the next VDE pixel will take in its line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d1 <= 1'b0;
            vde_d1   <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            tl_sh    <= '0;
            br_sh    <= '0;
            en_sh    <= '0;
            dec_sh   <= '0;
        end else begin
            vsync_d1 <= vid_pVSync_i;
            vde_d1   <= vid_pVDE_i;
            if (frame_start) begin
                tl_sh  <= top_left;
                br_sh  <= bottom_right;
                en_sh  <= win_enable;
                dec_sh <= decim_log2;
            end
            if (vid_pVDE_i) begin
                x_cnt <= (x_eff == '1) ? x_eff : x_eff + COORD_W'(1);
            end else if (line_end || frame_start) begin
                x_cnt <= '0;
            end
            if (frame_start) begin
                y_cnt <= '0;
            end else if (line_end) begin
                y_cnt <= (y_cnt == '1) ? y_cnt : y_cnt + COORD_W'(1);
            end
        end
    end

    // Only a frame entered from VBLANK is complete enough to publish its pixel count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count       <= '0;
            last_frame_pixels <= '0;
            pix_acc           <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 32'd1;
            if (state == ST_VBLANK) begin
                last_frame_pixels <= pix_acc;
            end
            pix_acc <= vde_next ? 32'd1 : 32'd0;
        end else if (vde_next) begin
            pix_acc <= sat_inc32(pix_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_pData_o  <= '0;
            vid_pHSync_o <= 1'b0;
            vid_pVSync_o <= 1'b0;
            vid_pVDE_o   <= 1'b0;
            win_hit      <= '0;
        end else begin
            vid_pData_o  <= vid_pData_i;
            vid_pHSync_o <= vid_pHSync_i;
            vid_pVSync_o <= vid_pVSync_i;
            vid_pVDE_o   <= vde_next;
            win_hit      <= hit & {N_WIN{pix_valid}};
        end
    end

endmodule
